// File: rtl/pkg_tpu.sv
// Shared defaults and clear-FSM state type for the multi-ported register file.
package pkg_tpu;

  localparam int RF_WIDTH  = 32;
  localparam int RF_DEPTH  = 64;
  localparam int RF_NUM_RD = 3;
  localparam int RF_NUM_WR = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rf_clr_state_t;

endpackage

// File: rtl/regfile_mp_clear_fsm.sv
// Clear sequencer: walks every entry once, zeroing one per cycle, while busy_o is high.
//   state | meaning
//   IDLE  | normal operation, waiting for a clear pulse
//   CLEAR | zeroing entry clr_idx_o this cycle; storage ports blocked
module regfile_mp_clear_fsm
  import pkg_tpu::*;
#(
  parameter  int DEPTH = RF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear_i,
  output logic          busy_o,
  output logic [AW-1:0] clr_idx_o
);

  rf_clr_state_t state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter wraps naturally from DEPTH-1 back to 0 on the exit cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clear_i) state_d = CLEAR;
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(DEPTH - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o    = (state_q == CLEAR);
  assign clr_idx_o = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with registered reads and a sequenced clear.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle write data to colliding reads.
module regfile_mp
  import pkg_tpu::*;
#(
  parameter  int WIDTH  = RF_WIDTH,
  parameter  int DEPTH  = RF_DEPTH,
  parameter  int NUM_RD = RF_NUM_RD,
  parameter  int NUM_WR = RF_NUM_WR,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    I_Req,
  input  logic [NUM_WR-1:0]       I_We,
  input  logic [NUM_WR*AW-1:0]    I_Index_Dst,
  input  logic [NUM_WR*WIDTH-1:0] I_Data,
  input  logic [NUM_RD-1:0]       I_Re,
  input  logic [NUM_RD*AW-1:0]    I_Index_Src,
  input  logic                    I_Clear,
  output logic [NUM_RD*WIDTH-1:0] O_Data_Src,
  output logic [NUM_RD-1:0]       O_Valid,
  output logic                    O_Busy
);

  logic [WIDTH-1:0]        mem_q [DEPTH];
  logic                    busy;
  logic [AW-1:0]           clr_idx;
  logic [NUM_RD-1:0]       fire;
  logic [NUM_RD*WIDTH-1:0] rdata_d, rdata_q;
  logic [NUM_RD-1:0]       valid_q;

  regfile_mp_clear_fsm #(.DEPTH(DEPTH)) u_clear_fsm (
    .clock     (clock),
    .reset     (reset),
    .clear_i   (I_Clear),
    .busy_o    (busy),
    .clr_idx_o (clr_idx)
  );

  assign fire = {NUM_RD{I_Req & ~busy}} & I_Re;

  always_comb begin
    rdata_d = rdata_q;
    for (int k = 0; k < NUM_RD; k++) begin
      if (fire[k]) begin
        rdata_d[k*WIDTH +: WIDTH] = mem_q[I_Index_Src[k*AW +: AW]];
`ifdef REGFILE_MP_BYPASS_EN
        // Ascending scan so the highest write port wins, matching the storage update.
        for (int j = 0; j < NUM_WR; j++) begin
          if (I_We[j] && !I_Clear && (I_Index_Dst[j*AW +: AW] == I_Index_Src[k*AW +: AW]))
            rdata_d[k*WIDTH +: WIDTH] = I_Data[j*WIDTH +: WIDTH];
        end
`endif
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
      valid_q <= '0;
    end else begin
      rdata_q <= rdata_d;
      valid_q <= fire;
    end
  end

  // Storage is deliberately not reset so an aborted clear leaves untouched entries intact.
  always_ff @(posedge clock) begin
    if (busy) begin
      mem_q[clr_idx] <= '0;
    end else if (!I_Clear) begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (I_We[j]) mem_q[I_Index_Dst[j*AW +: AW]] <= I_Data[j*WIDTH +: WIDTH];
      end
    end
  end

  assign O_Data_Src = rdata_q;
  assign O_Valid    = valid_q;
  assign O_Busy     = busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized and directed bench for regfile_mp against an array-based reference model.
module tb_regfile_mp;

  localparam int W  = 32;
  localparam int D  = 64;
  localparam int NR = 3;
  localparam int NW = 2;
  localparam int AW = 6;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            I_Req = 1'b0;
  logic            I_Clear = 1'b0;
  logic [NW-1:0]   I_We = '0;
  logic [NW*AW-1:0] I_Index_Dst = '0;
  logic [NW*W-1:0] I_Data = '0;
  logic [NR-1:0]   I_Re = '0;
  logic [NR*AW-1:0] I_Index_Src = '0;
  logic [NR*W-1:0] O_Data_Src;
  logic [NR-1:0]   O_Valid;
  logic            O_Busy;

  regfile_mp #(.WIDTH(W), .DEPTH(D), .NUM_RD(NR), .NUM_WR(NW)) dut (
    .clock       (clock),
    .reset       (reset),
    .I_Req       (I_Req),
    .I_We        (I_We),
    .I_Index_Dst (I_Index_Dst),
    .I_Data      (I_Data),
    .I_Re        (I_Re),
    .I_Index_Src (I_Index_Src),
    .I_Clear     (I_Clear),
    .O_Data_Src  (O_Data_Src),
    .O_Valid     (O_Valid),
    .O_Busy      (O_Busy)
  );

  always #5 clock = ~clock;

  int         n_vec = 0;
  int         n_err = 0;
  logic [W-1:0] mem_m [D];
  logic [W-1:0] exp_rd [NR];
  logic         exp_vld [NR];
  int           clr_left = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rd_out(input int k);
    return O_Data_Src[k*W +: W];
  endfunction

  task automatic idle_in();
    I_Req   = 1'b0;
    I_We    = '0;
    I_Re    = '0;
    I_Clear = 1'b0;
  endtask

  task automatic wr(input int j, input int idx, input logic [W-1:0] d);
    I_We[j] = 1'b1;
    I_Index_Dst[j*AW +: AW] = AW'(idx);
    I_Data[j*W +: W] = d;
  endtask

  task automatic rd(input int k, input int idx);
    I_Req   = 1'b1;
    I_Re[k] = 1'b1;
    I_Index_Src[k*AW +: AW] = AW'(idx);
  endtask

  // Model one clock edge from the current inputs, then compare every output.
  task automatic tick();
    logic          busy_m;
    logic [W-1:0]  v;
    logic [AW-1:0] ia;
    busy_m = (clr_left > 0);
    for (int k = 0; k < NR; k++) begin
      if (I_Req && I_Re[k] && !busy_m) begin
        ia = I_Index_Src[k*AW +: AW];
        v  = mem_m[ia];
`ifdef REGFILE_MP_BYPASS_EN
        for (int j = 0; j < NW; j++)
          if (I_We[j] && !I_Clear && I_Index_Dst[j*AW +: AW] == ia) v = I_Data[j*W +: W];
`endif
        exp_rd[k]  = v;
        exp_vld[k] = 1'b1;
      end else begin
        exp_vld[k] = 1'b0;
      end
    end
    if (busy_m) begin
      mem_m[AW'(D - clr_left)] = '0;
      clr_left--;
    end else if (I_Clear) begin
      clr_left = D;
    end else begin
      for (int j = 0; j < NW; j++)
        if (I_We[j]) mem_m[I_Index_Dst[j*AW +: AW]] = I_Data[j*W +: W];
    end
    @(posedge clock);
    #1;
    for (int k = 0; k < NR; k++) begin
      check($sformatf("valid%0d", k), 32'(O_Valid[k]), 32'(exp_vld[k]));
      check($sformatf("data%0d", k), rd_out(k), exp_rd[k]);
    end
    check("busy", 32'(O_Busy), 32'(clr_left > 0));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_busy", 32'(O_Busy), 32'h0);
    for (int k = 0; k < NR; k++) begin
      check($sformatf("rst_valid%0d", k), 32'(O_Valid[k]), 32'h0);
      check($sformatf("rst_data%0d", k), rd_out(k), 32'h0);
      exp_rd[k]  = '0;
      exp_vld[k] = 1'b0;
    end
    clr_left = 0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  function automatic int pick_idx();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, D - 1));
    return int'($urandom_range(0, 7));
  endfunction

  int busy_cnt;

  initial begin
    for (int i = 0; i < D; i++) mem_m[AW'(i)] = '0;
    idle_in();
    #2;
    do_reset();

    // Bring storage to a known all-zero state.
    I_Clear = 1'b1;
    tick();
    I_Clear = 1'b0;
    repeat (D) tick();

    // Write then read back on another port.
    wr(0, 5, 32'hDEADBEEF);
    tick();
    idle_in();
    rd(1, 5);
    tick();
    idle_in();
    check("r033_data", rd_out(1), 32'hDEADBEEF);
    check("r033_valid", 32'(O_Valid[1]), 32'h1);

    // Same-index write collision: highest port wins.
    wr(0, 9, 32'h1);
    wr(1, 9, 32'h2);
    tick();
    idle_in();
    rd(0, 9);
    rd(2, 9);
    tick();
    idle_in();
    check("r034_p0", rd_out(0), 32'h2);
    check("r034_p2", rd_out(2), 32'h2);

    // Read without I_Req holds data and drops valid.
    I_Re[2] = 1'b1;
    tick();
    idle_in();
    check("r038_valid", 32'(O_Valid[2]), 32'h0);
    check("r038_data", rd_out(2), 32'h2);

    // Read colliding with a write to the same entry.
    wr(0, 3, 32'hA);
    tick();
    idle_in();
    wr(0, 3, 32'hB);
    rd(0, 3);
    tick();
    idle_in();
`ifdef REGFILE_MP_BYPASS_EN
    check("r035_bypass", rd_out(0), 32'hB);
`else
    check("r035_nobypass", rd_out(0), 32'hA);
`endif

    // Random traffic, including occasional clears and resets.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      I_Req   = ($urandom_range(0, 3) != 0);
      I_Re    = NR'($urandom);
      I_We    = NW'($urandom);
      I_Clear = ($urandom_range(0, 299) == 0);
      for (int j = 0; j < NW; j++) begin
        I_Index_Dst[j*AW +: AW] = AW'(pick_idx());
        I_Data[j*W +: W] = $urandom;
      end
      for (int k = 0; k < NR; k++) I_Index_Src[k*AW +: AW] = AW'(pick_idx());
      tick();
    end
    idle_in();
    while (clr_left > 0) tick();

    // Full clear: busy length, dropped write, all entries read zero.
    for (int e = 0; e < D; e += 2) begin
      wr(0, e, 32'hC0DE_0000 | 32'(e));
      wr(1, e + 1, 32'hBEEF_0000 | 32'(e));
      tick();
      idle_in();
    end
    I_Clear = 1'b1;
    tick();
    I_Clear = 1'b0;
    busy_cnt = O_Busy ? 1 : 0;
    for (int i = 0; i < 70; i++) begin
      if (i == 20) wr(0, 7, 32'h77);
      tick();
      idle_in();
      if (O_Busy) busy_cnt++;
    end
    check("r036_busy_len", 32'(busy_cnt), 32'd64);
    for (int e = 0; e < D; e += NR) begin
      for (int k = 0; k < NR; k++) rd(k, (e + k) % D);
      tick();
      idle_in();
      for (int k = 0; k < NR; k++) check($sformatf("r036_zero%0d", k), rd_out(k), 32'h0);
    end

    // Reset part-way through a clear.
    wr(0, 20, 32'h1234_5678);
    wr(1, 5, 32'h55);
    tick();
    idle_in();
    I_Clear = 1'b1;
    tick();
    I_Clear = 1'b0;
    repeat (10) tick();
    do_reset();
    rd(0, 20);
    rd(1, 5);
    tick();
    idle_in();
    check("r037_keep20", rd_out(0), 32'h1234_5678);
    check("r037_zero5", rd_out(1), 32'h0);
    check("r037_busy", 32'(O_Busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
